// File: rtl/io_peripheral_pkg.sv
// Shared command/response/state encodings for the IO peripheral responder.
// The status helper packs the three 8-bit counters into the low 24 bits of a STATUS word.
package io_peripheral_pkg;

  typedef enum logic [1:0] {
    CMD_NOP    = 2'b00,
    CMD_WRITE  = 2'b01,
    CMD_READ   = 2'b10,
    CMD_STATUS = 2'b11
  } cmd_e;

  typedef enum logic [1:0] {
    RESP_NONE = 2'b00,
    RESP_ACK  = 2'b01,
    RESP_DATA = 2'b10,
    RESP_ERR  = 2'b11
  } resp_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } state_e;

  localparam int STAT_W = 8;

  function automatic logic [3*STAT_W-1:0] pack_status(input logic [STAT_W-1:0] tx_cnt,
                                                      input logic [STAT_W-1:0] rx_cnt,
                                                      input logic [STAT_W-1:0] drop_cnt);
    return {drop_cnt, rx_cnt, tx_cnt};
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy count; full/empty derive from that count,
// so a push on full or pop on empty is refused even if the other side moves in the same cycle.
module sync_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4,
  localparam int AW = $clog2(FIFO_DEPTH),
  localparam int CW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] pop_data,
  output logic [CW-1:0]         count,
  output logic                  full,
  output logic                  empty
);

  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [CW-1:0]         r_count;
  logic                  w_push;
  logic                  w_pop;

  assign full     = (r_count == CW'(FIFO_DEPTH));
  assign empty    = (r_count == '0);
  assign count    = r_count;
  assign pop_data = r_mem[r_rd_ptr];
  assign w_push   = push && !full;
  assign w_pop    = pop && !empty;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage carries no reset; validity is tracked by the pointers and count.
  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wr_ptr] <= push_data;
  end

endmodule

// File: rtl/io_peripheral_responder.sv
// Command responder: core issues WRITE/READ/STATUS, serviced through TX/RX FIFOs
// shared with a host port; one response per accepted command, two cycles after acceptance.
module io_peripheral_responder
  import io_peripheral_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [1:0]            to_peripheral,
  input  logic [DATA_WIDTH-1:0] to_peripheral_data,
  input  logic                  to_peripheral_valid,
  output logic [1:0]            from_peripheral,
  output logic [DATA_WIDTH-1:0] from_peripheral_data,
  output logic                  from_peripheral_valid,
  output logic [DATA_WIDTH-1:0] host_tx_data,
  output logic                  host_tx_valid,
  input  logic                  host_tx_ready,
  input  logic [DATA_WIDTH-1:0] host_rx_data,
  input  logic                  host_rx_valid,
  output logic                  host_rx_ready
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_e                r_state;
  state_e                w_state_nxt;
  cmd_e                  r_cmd;
  logic [DATA_WIDTH-1:0] r_cmd_data;
  resp_e                 r_resp_code;
  resp_e                 w_resp_code;
  logic [DATA_WIDTH-1:0] r_resp_data;
  logic [DATA_WIDTH-1:0] w_resp_data;
  logic [STAT_W-1:0]     r_drop_cnt;
  logic                  w_cmd_hit;
  logic                  w_tx_push;
  logic                  w_rx_pop;
  logic [DATA_WIDTH-1:0] w_tx_head;
  logic [DATA_WIDTH-1:0] w_rx_head;
  logic [CW-1:0]         w_tx_count;
  logic [CW-1:0]         w_rx_count;
  logic                  w_tx_full;
  logic                  w_tx_empty;
  logic                  w_rx_full;
  logic                  w_rx_empty;

  assign w_cmd_hit = to_peripheral_valid && (to_peripheral != CMD_NOP);

  sync_fifo #(.DATA_WIDTH(DATA_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (w_tx_push),
    .push_data (r_cmd_data),
    .pop       (host_tx_ready),
    .pop_data  (w_tx_head),
    .count     (w_tx_count),
    .full      (w_tx_full),
    .empty     (w_tx_empty)
  );

  sync_fifo #(.DATA_WIDTH(DATA_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (host_rx_valid),
    .push_data (host_rx_data),
    .pop       (w_rx_pop),
    .pop_data  (w_rx_head),
    .count     (w_rx_count),
    .full      (w_rx_full),
    .empty     (w_rx_empty)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_cmd       <= CMD_NOP;
      r_resp_code <= RESP_NONE;
      r_drop_cnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_IDLE && w_cmd_hit) r_cmd <= cmd_e'(to_peripheral);
      if (r_state == ST_EXEC) r_resp_code <= w_resp_code;
      if (r_state != ST_IDLE && w_cmd_hit && r_drop_cnt != '1) r_drop_cnt <= r_drop_cnt + 8'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (r_state == ST_IDLE && w_cmd_hit) r_cmd_data <= to_peripheral_data;
    if (r_state == ST_EXEC) r_resp_data <= w_resp_data;
  end

  // EXEC decides full/empty from the counts registered at the start of the cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_tx_push   = 1'b0;
    w_rx_pop    = 1'b0;
    w_resp_code = RESP_NONE;
    w_resp_data = '0;
    unique case (r_state)
      ST_IDLE: if (w_cmd_hit) w_state_nxt = ST_EXEC;
      ST_EXEC: begin
        w_state_nxt = ST_RESP;
        unique case (r_cmd)
          CMD_WRITE: begin
            if (!w_tx_full) begin
              w_tx_push   = 1'b1;
              w_resp_code = RESP_ACK;
            end else begin
              w_resp_code = RESP_ERR;
            end
          end
          CMD_READ: begin
            if (!w_rx_empty) begin
              w_rx_pop    = 1'b1;
              w_resp_code = RESP_DATA;
              w_resp_data = w_rx_head;
            end else begin
              w_resp_code = RESP_ERR;
            end
          end
          CMD_STATUS: begin
            w_resp_code = RESP_DATA;
            w_resp_data = DATA_WIDTH'(pack_status(STAT_W'(w_tx_count), STAT_W'(w_rx_count),
                                                  r_drop_cnt));
          end
          default: w_resp_code = RESP_NONE;
        endcase
      end
      ST_RESP: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign from_peripheral_valid = (r_state == ST_RESP);
  assign from_peripheral       = from_peripheral_valid ? r_resp_code : RESP_NONE;
  assign from_peripheral_data  = from_peripheral_valid ? r_resp_data : '0;
  assign host_tx_valid         = !w_tx_empty;
  assign host_tx_data          = w_tx_empty ? '0 : w_tx_head;
  // Gated by reset so the host sees not-ready while reset is held.
  assign host_rx_ready         = reset && !w_rx_full;

endmodule

// File: tb/tb_io_peripheral_responder.sv
// Bench for io_peripheral_responder: queue-based transaction model checked every cycle,
// directed scenarios with literal expectations, then a randomized traffic phase.
module tb_io_peripheral_responder;

  localparam int DW    = 32;
  localparam int DEPTH = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [1:0]    to_peripheral = 2'b00;
  logic [DW-1:0] to_peripheral_data = '0;
  logic          to_peripheral_valid = 1'b0;
  logic [1:0]    from_peripheral;
  logic [DW-1:0] from_peripheral_data;
  logic          from_peripheral_valid;
  logic [DW-1:0] host_tx_data;
  logic          host_tx_valid;
  logic          host_tx_ready = 1'b0;
  logic [DW-1:0] host_rx_data = '0;
  logic          host_rx_valid = 1'b0;
  logic          host_rx_ready;

  io_peripheral_responder #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clock                 (clock),
    .reset                 (reset),
    .to_peripheral         (to_peripheral),
    .to_peripheral_data    (to_peripheral_data),
    .to_peripheral_valid   (to_peripheral_valid),
    .from_peripheral       (from_peripheral),
    .from_peripheral_data  (from_peripheral_data),
    .from_peripheral_valid (from_peripheral_valid),
    .host_tx_data          (host_tx_data),
    .host_tx_valid         (host_tx_valid),
    .host_tx_ready         (host_tx_ready),
    .host_rx_data          (host_rx_data),
    .host_rx_valid         (host_rx_valid),
    .host_rx_ready         (host_rx_ready)
  );

  initial forever #5 clock = ~clock;

  // Reference model: FIFO contents as queues, a drop counter, and the age of the
  // command in flight (1 = operation happens at the next edge, 2 = response on display).
  logic [DW-1:0] txq[$];
  logic [DW-1:0] rxq[$];
  int            m_drops = 0;
  int            m_age = 0;
  logic [1:0]    m_cmd = 2'b00;
  logic [DW-1:0] m_cmd_data = '0;
  logic [1:0]    m_rc = 2'b00;
  logic [DW-1:0] m_rd = '0;

  initial begin : model
    int tsz;
    int rsz;
    bit hit;
    bit tx_pop;
    bit rx_push;
    bit core_push;
    bit core_pop;
    forever begin
      @(posedge clock or negedge reset);
      if (!reset) begin
        txq.delete();
        rxq.delete();
        m_drops = 0;
        m_age   = 0;
        m_rc    = 2'b00;
        m_rd    = '0;
      end else begin
        tsz       = txq.size();
        rsz       = rxq.size();
        hit       = to_peripheral_valid && (to_peripheral != 2'b00);
        tx_pop    = host_tx_ready && (tsz > 0);
        rx_push   = host_rx_valid && (rsz < DEPTH);
        core_push = 1'b0;
        core_pop  = 1'b0;
        if (m_age == 1) begin
          m_rd = '0;
          case (m_cmd)
            2'b01: if (tsz < DEPTH) begin core_push = 1'b1; m_rc = 2'b01; end
                   else m_rc = 2'b11;
            2'b10: if (rsz > 0) begin core_pop = 1'b1; m_rc = 2'b10; m_rd = rxq[0]; end
                   else m_rc = 2'b11;
            default: begin
              m_rc = 2'b10;
              m_rd = (32'(m_drops) << 16) | (32'(rsz) << 8) | 32'(tsz);
            end
          endcase
        end
        if (hit && m_age == 0) begin
          m_cmd      = to_peripheral;
          m_cmd_data = to_peripheral_data;
        end else if (hit && m_drops < 255) begin
          m_drops++;
        end
        if (tx_pop)    void'(txq.pop_front());
        if (core_push) txq.push_back(m_cmd_data);
        if (core_pop)  void'(rxq.pop_front());
        if (rx_push)   rxq.push_back(host_rx_data);
        if (m_age == 0)      m_age = hit ? 1 : 0;
        else if (m_age == 1) m_age = 2;
        else                 m_age = 0;
      end
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    logic          ev;
    logic [1:0]    ec;
    logic [DW-1:0] ed;
    ev = reset && (m_age == 2);
    ec = ev ? m_rc : 2'b00;
    ed = ev ? m_rd : '0;
    chk("resp_valid", 32'(from_peripheral_valid), 32'(ev));
    chk("resp_code", 32'(from_peripheral), 32'(ec));
    chk("resp_data", from_peripheral_data, ed);
    chk("tx_valid", 32'(host_tx_valid), 32'(txq.size() != 0));
    if (txq.size() != 0) chk("tx_data", host_tx_data, txq[0]);
    if (!reset) chk("tx_data_in_reset", host_tx_data, 32'h0);
    chk("rx_ready", 32'(host_rx_ready), 32'(reset && rxq.size() < DEPTH));
  endtask

  // Advance one cycle: inputs set before this take effect at the coming rising edge;
  // returns at the following falling edge after checking the model.
  task automatic tick();
    @(negedge clock);
    compare_all();
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic do_cmd(input logic [1:0] code, input logic [31:0] data,
                        input logic [1:0] exp_code, input logic [31:0] exp_data,
                        input string name);
    to_peripheral       = code;
    to_peripheral_data  = data;
    to_peripheral_valid = 1'b1;
    tick();
    to_peripheral_valid = 1'b0;
    to_peripheral       = 2'b00;
    tick();
    chk({name, "_valid"}, 32'(from_peripheral_valid), 32'h1);
    chk({name, "_code"}, 32'(from_peripheral), 32'(exp_code));
    chk({name, "_data"}, from_peripheral_data, exp_data);
    tick();
  endtask

  initial begin : main
    #1 reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    #1 chk("rx_ready_after_reset", 32'(host_rx_ready), 32'h1);
    tick();

    do_cmd(2'b11, 32'h0, 2'b10, 32'h0000_0000, "status_reset");
    do_cmd(2'b01, 32'hDEAD_BEEF, 2'b01, 32'h0, "write_beef");
    chk("beef_tx_valid", 32'(host_tx_valid), 32'h1);
    chk("beef_tx_data", host_tx_data, 32'hDEAD_BEEF);
    do_cmd(2'b11, 32'h0, 2'b10, 32'h0000_0001, "status_one");

    pulse_reset();
    for (int i = 0; i < 4; i++) do_cmd(2'b01, 32'hA0 + i, 2'b01, 32'h0, "fill_ack");
    do_cmd(2'b01, 32'hA4, 2'b11, 32'h0, "fill_err");
    host_tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_valid", 32'(host_tx_valid), 32'h1);
      chk("drain_data", host_tx_data, 32'hA0 + i);
      tick();
    end
    host_tx_ready = 1'b0;
    chk("drained_empty", 32'(host_tx_valid), 32'h0);

    do_cmd(2'b10, 32'h0, 2'b11, 32'h0, "read_empty");
    host_rx_data  = 32'h11;
    host_rx_valid = 1'b1;
    tick();
    host_rx_valid = 1'b0;
    do_cmd(2'b10, 32'h0, 2'b10, 32'h0000_0011, "read_11");

    pulse_reset();
    to_peripheral       = 2'b01;
    to_peripheral_data  = 32'h5;
    to_peripheral_valid = 1'b1;
    tick();
    to_peripheral_data  = 32'h6;
    tick();
    to_peripheral_valid = 1'b0;
    to_peripheral       = 2'b00;
    chk("single_ack", 32'(from_peripheral), 32'h1);
    tick();
    chk("no_second_resp", 32'(from_peripheral_valid), 32'h0);
    do_cmd(2'b11, 32'h0, 2'b10, 32'h0001_0001, "status_drop1");
    to_peripheral       = 2'b11;
    to_peripheral_valid = 1'b1;
    for (int i = 0; i < 600; i++) tick();
    to_peripheral_valid = 1'b0;
    to_peripheral       = 2'b00;
    for (int i = 0; i < 3; i++) tick();
    do_cmd(2'b11, 32'h0, 2'b10, 32'h00FF_0001, "status_drop_sat");

    pulse_reset();
    host_rx_data  = 32'h22;
    host_rx_valid = 1'b1;
    tick();
    host_rx_valid = 1'b0;
    to_peripheral       = 2'b10;
    to_peripheral_valid = 1'b1;
    tick();
    to_peripheral_valid = 1'b0;
    to_peripheral       = 2'b00;
    reset = 1'b0;
    #1;
    chk("abort_no_valid", 32'(from_peripheral_valid), 32'h0);
    chk("abort_rx_ready", 32'(host_rx_ready), 32'h0);
    chk("abort_tx_valid", 32'(host_tx_valid), 32'h0);
    tick();
    reset = 1'b1;
    #1 chk("release_rx_ready", 32'(host_rx_ready), 32'h1);
    chk("release_no_resp", 32'(from_peripheral_valid), 32'h0);
    do_cmd(2'b11, 32'h0, 2'b10, 32'h0000_0000, "status_after_abort");

    pulse_reset();
    for (int i = 0; i < 2000; i++) begin
      reset               = ($urandom_range(299) != 0);
      to_peripheral_valid = ($urandom_range(2) == 0);
      to_peripheral       = 2'($urandom_range(3));
      to_peripheral_data  = $urandom;
      host_tx_ready       = ($urandom_range(2) == 0);
      host_rx_valid       = ($urandom_range(1) == 0);
      host_rx_data        = $urandom;
      tick();
    end
    reset               = 1'b1;
    to_peripheral_valid = 1'b0;
    host_rx_valid       = 1'b0;
    host_tx_ready       = 1'b0;
    for (int i = 0; i < 4; i++) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/io_peripheral_responder.md
IO_PERIPHERAL_RESPONDER -- requirements
Module: io_peripheral_responder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of the command and response data words; legal values are 32 or more.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, entries per TX/RX FIFO; legal values are powers of 2 from 2 to 128.
REQ-003 SHALL have port clock  in  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-low reset (reset==0 resets).
REQ-005 SHALL have port to_peripheral  in  2  command code from core: 00 NOP, 01 WRITE, 10 READ, 11 STATUS.
REQ-006 SHALL have port to_peripheral_data  in  DATA_WIDTH  WRITE payload; ignored for other commands.
REQ-007 SHALL have port to_peripheral_valid  in  1  command qualifier, one-cycle pulse per command.
REQ-008 SHALL have port from_peripheral  out  2  response code: 00 NONE, 01 ACK, 10 DATA, 11 ERR.
REQ-009 SHALL have port from_peripheral_data  out  DATA_WIDTH  response payload.
REQ-010 SHALL have port from_peripheral_valid  out  1  response qualifier, one-cycle pulse.
REQ-011 SHALL have port host_tx_data  out  DATA_WIDTH  head of TX FIFO.
REQ-012 SHALL have port host_tx_valid  out  1  TX FIFO not empty.
REQ-013 SHALL have port host_tx_ready  in  1  external sink pops TX head when valid&ready.
REQ-014 SHALL have port host_rx_data  in  DATA_WIDTH  word from external source.
REQ-015 SHALL have port host_rx_valid  in  1  external source offers host_rx_data.
REQ-016 SHALL have port host_rx_ready  out  1  RX FIFO not full; push when valid&ready.

Function
REQ-017 SHALL implement FSM IDLE -> EXEC -> RESP -> IDLE; a command with valid=1 and code!=00 in IDLE is latched and moves the FSM to EXEC.
REQ-018 SHALL ignore NOP (code 00) entirely: no response, no state change.
REQ-019 SHALL in EXEC perform the operation; SHALL in RESP drive from_peripheral_valid=1 for exactly one cycle, so the response appears two cycles after command acceptance.
REQ-020 WRITE: SHALL push to the TX FIFO and respond ACK with data 0 if not full; if full, SHALL not push and respond ERR with data 0.
REQ-021 READ: SHALL pop the RX FIFO and respond DATA with the popped word if not empty; if empty, SHALL respond ERR with data 0.
REQ-022 STATUS: SHALL respond DATA with [7:0]=tx_count, [15:8]=rx_count, [23:16]=drop_count, all upper bits 0.
REQ-023 Full/empty decisions in EXEC SHALL use the FIFO count registered at the start of that cycle; a same-cycle host pop or push SHALL not rescue a full or empty condition.
REQ-024 A valid non-NOP command arriving in EXEC or RESP SHALL be dropped without a response and SHALL increment drop_count, which saturates at 255.
REQ-025 Host-side pops and pushes SHALL proceed every cycle, independent of FSM state.
REQ-026 A simultaneous core pop and host push on the RX FIFO, or core push and host pop on the TX FIFO, SHALL leave the count unchanged and preserve FIFO order.
REQ-027 Both FIFO pointers SHALL wrap modulo FIFO_DEPTH; each count SHALL range 0..FIFO_DEPTH.
REQ-028 When no response is pending, from_peripheral SHALL be 00 and from_peripheral_data SHALL be 0.

Reset
REQ-029 On reset==0, the block SHALL immediately set the FSM to IDLE, empty both FIFOs, clear drop_count, and drive all outputs to 0 (host_rx_ready = 0).
REQ-030 Reset asserted mid-command SHALL abort the command with no response; the first cycle after reset release SHALL be able to accept a command, and host_rx_ready SHALL be 1 from that cycle.

Structure
REQ-031 The command codes, response codes, and FSM state encodings SHALL live in a shared package or header (io_peripheral_pkg).
REQ-032 The TX and RX FIFOs SHALL be two instances of one sub-module, sync_fifo, with DATA_WIDTH and FIFO_DEPTH parameters and count, full, and empty outputs.

Verification
REQ-033 Reset then STATUS -> DATA 0x00000000 two cycles after the command; host_rx_ready=1.
REQ-034 WRITE 0xDEADBEEF with host_tx_ready=0 -> ACK; host_tx_valid=1; host_tx_data=0xDEADBEEF; STATUS -> 0x00000001.
REQ-035 5 WRITEs with FIFO_DEPTH=4 and host_tx_ready=0 -> 4 ACK then ERR; then host drains and values are seen in order.
REQ-036 READ on empty RX -> ERR data 0; host pushes 0x11, then READ -> DATA 0x00000011.
REQ-037 Second WRITE pulsed one cycle after the first -> only one ACK; STATUS [23:16]=0x01; 300 such drops -> 0xFF.
REQ-038 Assert reset during EXEC of a READ with RX holding 0x22 -> no response; RX empty after release; next STATUS -> 0x00000000.
